// File: rtl/rpn_sequencer.sv
// RPN evaluator that drives an external LIFO stack through push/pop/din/dout.
// Tracks stack occupancy itself and reports each operator result on a one-cycle strobe.
module rpn_sequencer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tok_valid,
   output logic                     tok_ready,
   input  logic                     tok_is_op,
   input  logic [WIDTH-1:0]         tok_data,
   output logic                     stk_push,
   output logic                     stk_pop,
   output logic [WIDTH-1:0]         stk_din,
   input  logic [WIDTH-1:0]         stk_dout,
   output logic                     res_valid,
   output logic [WIDTH-1:0]         result,
   output logic                     err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POP_B  = 3'd1,
      GET_B  = 3'd2,
      POP_A  = 3'd3,
      GET_A  = 3'd4,
      PUSH_R = 3'd5,
      ERROR  = 3'd6
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     count_nxt;
   logic [WIDTH-1:0]  a, a_nxt, b, b_nxt, r;
   logic [WIDTH-1:0]  result_nxt;
   logic [1:0]        op, op_nxt;
   logic              err_nxt, res_valid_nxt;

   // a is the deeper operand, so sub is a - b; carries and borrows wrap
   always_comb begin
      r = '0;
      case (op)
         2'b00:   r = a + b;
         2'b01:   r = a - b;
         2'b10:   r = a & b;
         default: r = a ^ b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         err       <= 1'b0;
         res_valid <= 1'b0;
         result    <= '0;
         a         <= '0;
         b         <= '0;
         op        <= '0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         err       <= err_nxt;
         res_valid <= res_valid_nxt;
         result    <= result_nxt;
         a         <= a_nxt;
         b         <= b_nxt;
         op        <= op_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      err_nxt       = err;
      res_valid_nxt = 1'b0;
      result_nxt    = result;
      a_nxt         = a;
      b_nxt         = b;
      op_nxt        = op;
      tok_ready     = 1'b0;
      stk_push      = 1'b0;
      stk_pop       = 1'b0;
      stk_din       = '0;

      case (state)
         IDLE: begin
            tok_ready = 1'b1;
            if (tok_valid) begin
               if (!tok_is_op) begin
                  if (count < CW'(DEPTH)) begin
                     stk_push  = 1'b1;
                     stk_din   = tok_data;
                     count_nxt = count + CW'(1);
                  end else begin
                     err_nxt   = 1'b1;
                     state_nxt = ERROR;
                  end
               end else if (count < CW'(2)) begin
                  err_nxt   = 1'b1;
                  state_nxt = ERROR;
               end else begin
                  op_nxt    = tok_data[1:0];
                  state_nxt = POP_B;
               end
            end
         end
         POP_B: begin
            stk_pop   = 1'b1;
            count_nxt = count - CW'(1);
            state_nxt = GET_B;
         end
         GET_B: begin
            b_nxt     = stk_dout;
            state_nxt = POP_A;
         end
         POP_A: begin
            stk_pop   = 1'b1;
            count_nxt = count - CW'(1);
            state_nxt = GET_A;
         end
         GET_A: begin
            a_nxt     = stk_dout;
            state_nxt = PUSH_R;
         end
         PUSH_R: begin
            stk_push      = 1'b1;
            stk_din       = r;
            count_nxt     = count + CW'(1);
            result_nxt    = r;
            res_valid_nxt = 1'b1;
            state_nxt     = IDLE;
         end
         ERROR: begin
            state_nxt = ERROR;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer: a behavioural LIFO serves the stack
// ports and a queue-based RPN evaluator supplies expected values.
module tb_rpn_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       tok_valid, tok_ready, tok_is_op;
   logic [3:0] tok_data;
   logic       stk_push, stk_pop;
   logic [3:0] stk_din, stk_dout;
   logic       res_valid, err;
   logic [3:0] result;
   logic [3:0] count;

   int errors = 0;
   int checks = 0;

   rpn_sequencer #(.WIDTH(4), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_ready(tok_ready),
      .tok_is_op(tok_is_op), .tok_data(tok_data), .stk_push(stk_push),
      .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
      .res_valid(res_valid), .result(result), .err(err), .count(count)
   );

   always #5 clk = ~clk;

   // Attached LIFO: dout is valid the cycle after a pop
   int tbstk[$];
   int cyc = 0;
   int acc_cyc[$], pop_cyc[$], push_cyc[$];
   int illegal = 0;

   always @(posedge clk) begin
      if (tok_valid && tok_ready) acc_cyc.push_back(cyc);
      if (stk_pop)  pop_cyc.push_back(cyc);
      if (stk_push) push_cyc.push_back(cyc);
      if (stk_push && stk_pop) illegal <= illegal + 1;
      if (rst) begin
         tbstk.delete();
         stk_dout <= 4'd0;
      end else begin
         if (stk_push) begin
            if (tbstk.size() >= 8) illegal <= illegal + 1;
            tbstk.push_back(int'(stk_din));
         end
         if (stk_pop) begin
            if (tbstk.size() == 0) illegal <= illegal + 1;
            else begin
               stk_dout <= 4'(tbstk[$]);
               tbstk.pop_back();
            end
         end
      end
      cyc <= cyc + 1;
   end

   function automatic int apply_op(input int opc, input int a, input int b);
      case (opc & 3)
         0:       return (a + b) & 15;
         1:       return (a - b) & 15;
         2:       return a & b;
         default: return a ^ b;
      endcase
   endfunction

   task automatic clear_log();
      acc_cyc.delete(); pop_cyc.delete(); push_cyc.delete();
   endtask

   task automatic do_reset();
      tok_valid = 0; tok_is_op = 0; tok_data = 0;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      clear_log();
   endtask

   // Present one token, wait for ready, return #1 after the accepting edge
   task automatic send(input bit is_op, input int d);
      int n = 0;
      tok_valid = 1; tok_is_op = is_op; tok_data = 4'(d);
      while (!tok_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!tok_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: tok_ready=%0d required 1", tok_ready);
      end else begin
         @(posedge clk); #1;
      end
      tok_valid = 0;
   endtask

   task automatic wait_ready(output int edges);
      int n = 0;
      while (!tok_ready && n < 20) begin @(posedge clk); #1; n++; end
      edges = n;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 4'd0)   begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
      checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %0d required 0", err); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0d required 0", res_valid); end
      checks++; if (result !== 4'd0)  begin errors++; $display("FAIL reset_result: got %0d required 0", result); end
      checks++; if (tok_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d required 1", tok_ready); end
      checks++; if ({stk_push, stk_pop, stk_din} !== 6'd0) begin errors++; $display("FAIL reset_stk: got %0h required 0", {stk_push, stk_pop, stk_din}); end
   endtask

   task automatic test_add();
      int e;
      do_reset();
      send(0, 3); send(0, 5); send(1, 0);
      wait_ready(e);
      checks++; if (e !== 5) begin errors++; $display("FAIL add_latency: got %0d edges required 5", e); end
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL add_res_valid: got %0d required 1", res_valid); end
      checks++; if (result !== 4'd8) begin errors++; $display("FAIL add_result: got %0d required 8", result); end
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL add_count: got %0d required 1", count); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err: got %0d required 0", err); end
      checks++;
      if (tbstk.size() != 1 || tbstk[0] != 8) begin
         errors++; $display("FAIL add_stack: size %0d top %0d required size 1 top 8", tbstk.size(), tbstk.size() ? tbstk[$] : -1);
      end
      checks++;
      if (acc_cyc.size() != 3 || pop_cyc.size() != 2 || push_cyc.size() != 3 ||
          pop_cyc[0] != acc_cyc[2] + 1 || pop_cyc[1] != acc_cyc[2] + 3 || push_cyc[2] != acc_cyc[2] + 5) begin
         errors++; $display("FAIL add_timing: accepts %0d pops %0d pushes %0d required pops at T+1,T+3 push at T+5",
                            acc_cyc.size(), pop_cyc.size(), push_cyc.size());
      end
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_strobe_len: got %0d required 0", res_valid); end
   endtask

   task automatic test_sub_wrap();
      int e;
      do_reset();
      send(0, 2); send(0, 5); send(1, 1);
      wait_ready(e);
      checks++; if (result !== 4'd13 || res_valid !== 1'b1) begin errors++; $display("FAIL sub_wrap: result %0d valid %0d required 13/1", result, res_valid); end
      send(0, 6); send(1, 3);
      wait_ready(e);
      checks++; if (result !== 4'd11 || res_valid !== 1'b1) begin errors++; $display("FAIL xor_result: result %0d valid %0d required 11/1", result, res_valid); end
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL xor_count: got %0d required 1", count); end
   endtask

   task automatic test_underflow();
      do_reset();
      send(0, 7); send(1, 0);
      checks++; if (err !== 1'b1 || tok_ready !== 1'b0) begin errors++; $display("FAIL underflow_err: err %0d ready %0d required 1/0", err, tok_ready); end
      tok_valid = 1; tok_is_op = 0; tok_data = 4'd2;
      repeat (8) begin @(posedge clk); #1; end
      tok_valid = 0;
      checks++; if (pop_cyc.size() != 0) begin errors++; $display("FAIL underflow_pop: got %0d pops required 0", pop_cyc.size()); end
      checks++; if (push_cyc.size() != 1) begin errors++; $display("FAIL underflow_push: got %0d pushes required 1", push_cyc.size()); end
      checks++; if (count !== 4'd1 || err !== 1'b1 || tok_ready !== 1'b0) begin errors++; $display("FAIL underflow_hold: count %0d err %0d ready %0d required 1/1/0", count, err, tok_ready); end
   endtask

   task automatic test_overflow();
      bit consec = 1;
      do_reset();
      tok_valid = 1; tok_is_op = 0;
      for (int i = 1; i <= 9; i++) begin
         tok_data = 4'(i);
         @(posedge clk); #1;
      end
      tok_valid = 0;
      for (int i = 1; i < push_cyc.size(); i++) if (push_cyc[i] != push_cyc[i-1] + 1) consec = 0;
      checks++; if (push_cyc.size() != 8 || !consec) begin errors++; $display("FAIL overflow_pushes: got %0d consec %0d required 8/1", push_cyc.size(), consec); end
      checks++; if (count !== 4'd8 || err !== 1'b1 || tok_ready !== 1'b0) begin errors++; $display("FAIL overflow_state: count %0d err %0d ready %0d required 8/1/0", count, err, tok_ready); end
      checks++; if (tbstk.size() != 8 || tbstk[7] != 8 || tbstk[0] != 1) begin errors++; $display("FAIL overflow_stack: size %0d required 8 holding 1..8", tbstk.size()); end
   endtask

   task automatic test_reset_midop();
      int e;
      int npush;
      do_reset();
      send(0, 4); send(0, 4); send(1, 2);
      wait_ready(e);
      checks++; if (result !== 4'd4) begin errors++; $display("FAIL midop_pre: result %0d required 4", result); end
      send(0, 4); send(0, 4); send(1, 2);
      @(posedge clk); #1;
      rst = 1;
      npush = push_cyc.size();
      @(posedge clk); #1;
      rst = 0;
      checks++; if (count !== 4'd0 || res_valid !== 1'b0 || result !== 4'd0 || tok_ready !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL midop_reset: count %0d valid %0d result %0d ready %0d err %0d required 0/0/0/1/0", count, res_valid, result, tok_ready, err);
      end
      repeat (6) begin @(posedge clk); #1; end
      checks++; if (push_cyc.size() != npush || res_valid !== 1'b0) begin errors++; $display("FAIL midop_abandon: pushes %0d valid %0d required %0d/0", push_cyc.size(), res_valid, npush); end
   endtask

   task automatic test_backpressure();
      int n = 0;
      do_reset();
      send(0, 1); send(0, 2);
      clear_log();
      tok_valid = 1; tok_is_op = 1; tok_data = 4'd0;
      @(posedge clk); #1;
      tok_is_op = 0; tok_data = 4'd9;
      while (acc_cyc.size() < 2 && n < 20) begin @(posedge clk); #1; n++; end
      tok_valid = 0;
      checks++; if (acc_cyc.size() != 2 || acc_cyc[1] != acc_cyc[0] + 6) begin
         errors++; $display("FAIL backpressure_accept: accepts %0d gap %0d required 2/6", acc_cyc.size(), acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1);
      end
      checks++; if (tbstk.size() != 2 || tbstk[0] != 3 || tbstk[1] != 9) begin errors++; $display("FAIL backpressure_order: size %0d required stack 3,9", tbstk.size()); end
      checks++; if (count !== 4'd2) begin errors++; $display("FAIL backpressure_count: got %0d required 2", count); end
   endtask

   task automatic test_random();
      int model[$];
      int e, d, a, b, r;
      bit is_op, bad;
      for (int round = 0; round < 12; round++) begin
         do_reset();
         model.delete();
         bad = 0;
         for (int k = 0; k < 30 && !bad; k++) begin
            is_op = ($urandom_range(0, 2) == 0);
            d = int'($urandom_range(0, 15));
            send(is_op, d);
            if (!is_op && model.size() == 8) bad = 1;
            else if (is_op && model.size() < 2) bad = 1;
            else if (!is_op) model.push_back(d);
            else begin
               b = model.pop_back(); a = model.pop_back();
               r = apply_op(d, a, b);
               model.push_back(r);
               wait_ready(e);
               checks++; if (e !== 5 || res_valid !== 1'b1 || result !== 4'(r)) begin
                  errors++; $display("FAIL rand_op: op %0d a %0d b %0d result %0d valid %0d edges %0d required %0d/1/5", d & 3, a, b, result, res_valid, e, r);
               end
            end
            checks++; if (err !== bad || count !== 4'(model.size())) begin
               errors++; $display("FAIL rand_state: err %0d count %0d required %0d/%0d", err, count, bad, model.size());
            end
         end
         checks++; if (tbstk != model) begin errors++; $display("FAIL rand_stack: size %0d required %0d", tbstk.size(), model.size()); end
      end
   endtask

   initial begin
      tok_valid = 0; tok_is_op = 0; tok_data = 0; rst = 1;
      test_reset();
      test_add();
      test_sub_wrap();
      test_underflow();
      test_overflow();
      test_reset_midop();
      test_backpressure();
      test_random();
      checks++; if (illegal !== 0) begin errors++; $display("FAIL stack_protocol: got %0d violations required 0", illegal); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
